dcache_load_resp: RTL and testbench
===================================

# dcache_load_resp

Load-response engine of the data cache. It sits between the dcache lookup stage and the Memory2 pipeline stage, and it is the producer side of Memory2's `rd_dcache_data` / `dcache_data_valid` / `dcache_data_ready` handshake. Hits return the data-array word directly. Cacheable misses run a line refill burst on the bus and return the requested word. Uncached loads run a single-beat read. A flush cancels the response but never aborts a bus transaction already issued.

## Interface
- `LINE_WORDS`, default 4: words per cache line; must be a power of 2 and at least 2.
- `OFF_W`, default $clog2(LINE_WORDS): word-offset width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  load request from the lookup stage.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_pa`  in  32  physical address.
- `req_uncached`  in  1  request is an uncached (SUC) load.
- `req_hit`  in  1  tag hit, valid with `req_valid`.
- `hit_data`  in  32  data-array word for a hit.
- `flush_i`  in  1  pipeline flush.
- `rd_dcache_data`  out  32  response word to Memory2.
- `dcache_data_valid`  out  1  response valid.
- `dcache_data_ready`  in  1  Memory2 accepts the response.
- `bus_ar_valid` / `bus_ar_ready`  out / in  1  read-address handshake.
- `bus_ar_addr`  out  32  read address.
- `bus_ar_len`  out  8  number of beats minus 1.
- `bus_r_valid`, `bus_r_last`  in  1  read-data beat valid; last beat.
- `bus_r_data`  in  32  read-data beat.
- `bus_r_ready`  out  1  high in REFILL only.
- `refill_we`  out  1  data-array word write strobe.
- `refill_off`  out  OFF_W  word offset being written.
- `refill_data`  out  32  word being written.
- `refill_done`  out  1  one-cycle pulse that sets the tag/valid bit.

## Operation
- States: IDLE, RESP, AR, REFILL. Reset puts the FSM in IDLE and drives every output to 0.
- Request acceptance:
  - `req_ready` = (IDLE) | (RESP & `dcache_data_valid` & `dcache_data_ready`). It is forced to 0 when `flush_i` is high.
  - An accepted hit (`req_hit` & ~`req_uncached`) latches `hit_data` into the response register and moves to RESP.
  - Any other accepted request latches `req_pa` and `req_uncached`, then moves to AR.
- AR state:
  - `bus_ar_valid` is held high until `bus_ar_ready`, then the FSM moves to REFILL.
  - Cacheable: address = {`pa[31:OFF_W+2]`, 0}, `bus_ar_len` = LINE_WORDS-1.
  - Uncached: address = {`pa[31:2]`, 2'b00}, `bus_ar_len` = 0.
- REFILL state:
  - An OFF_W-bit beat counter starts at 0 and increments on each `bus_r_valid` beat. Wrap is irrelevant because `r_last` ends the burst.
  - Cacheable beats drive `refill_we`=1, `refill_off`=counter, `refill_data`=`bus_r_data` in the same cycle as the beat.
  - The beat where counter == `pa[OFF_W+1:2]` (uncached: beat 0) is captured into the response register.
  - On the `bus_r_last` beat: a cacheable request pulses `refill_done` in that cycle, and the FSM moves to RESP, or to IDLE if cancelled.
- RESP state:
  - `dcache_data_valid` = 1.
  - Data is held stable while `dcache_data_ready` is 0.
  - On acceptance the FSM moves to IDLE, or reloads from a back-to-back accepted request.
- Flush:
  - In RESP or IDLE, `flush_i` drops the response and the FSM goes to IDLE next cycle. A `req_valid` in the flush cycle is ignored.
  - In AR or REFILL, `flush_i` sets a `cancel` flag. The bus burst and cache refill complete normally, the line stays valid, no response is produced, and the FSM then returns to IDLE. `cancel` clears on the IDLE entry.
- Reset mid-burst: the FSM returns to IDLE immediately. The bus fabric is reset on the same `rst_n`.

## Timing
- Hit: accepted at cycle T, `dcache_data_valid` at T+1. Back-to-back hits sustain 1 per cycle when `dcache_data_ready` is held high.
- Miss: `bus_ar_valid` at T+1.
- Response, without the macro: `dcache_data_valid` in the cycle after the `bus_r_last` beat.
- Response, with the macro: see Configuration.
- `refill_*` outputs are combinational from the `bus_r` beat, so there are zero cycles of latency to the array.
- `bus_r_ready` never depends on `dcache_data_ready`.

## Configuration
- `DCACHE_EARLY_RESTART_EN` defined:
  - For cacheable misses, `dcache_data_valid` asserts in the cycle after the critical beat, while REFILL continues in parallel.
  - A response accepted before `r_last` does not free the engine: `req_ready` stays 0 until the burst ends.
  - A flush after early acceptance has no effect on the response.
- Undefined: the response is produced only after `r_last`, as described under Operation.

## Test plan
- Hit: `req_pa`=0x1000_0008, `req_hit`=1, `hit_data`=0xDEAD_BEEF at T -> valid with 0xDEADBEEF at T+1. With `dcache_data_ready`=0 for 3 cycles, the data is held stable.
- Miss at `pa`=0x2000_0048, bus returns words 0xA0..0xA3 with 2-cycle `ar_ready` delay:
  - `ar_addr`=0x2000_0040, `len`=3.
  - `refill_we` on 4 beats with offsets 0..3.
  - `refill_done` on beat 3.
  - Response 0xA2.
- Uncached at `pa`=0x1FAF_0006 -> `ar_addr`=0x1FAF_0004, `len`=0, no `refill_we`, response = the beat data.
- Flush one cycle after `ar_valid` -> all 4 beats are still written, `refill_done` pulses, no `dcache_data_valid`, FSM is in IDLE the cycle after `r_last`.
- Flush in RESP together with a new `req_valid` hit -> valid drops next cycle and the new request is not accepted.
- With `DCACHE_EARLY_RESTART_EN`, critical word at offset 1 -> valid in the cycle after beat 1, and `req_ready`=0 until after `r_last`.

Source files
------------

// File: rtl/dcache_load_resp.sv
// Data-cache load-response engine: hit return, line refill on cacheable miss, single-beat uncached read.
// Optional DCACHE_EARLY_RESTART_EN: return the critical word of a refill before the burst finishes.
module dcache_load_resp #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_pa,
  input  logic             req_uncached,
  input  logic             req_hit,
  input  logic [31:0]      hit_data,
  input  logic             flush_i,
  output logic [31:0]      rd_dcache_data,
  output logic             dcache_data_valid,
  input  logic             dcache_data_ready,
  output logic             bus_ar_valid,
  input  logic             bus_ar_ready,
  output logic [31:0]      bus_ar_addr,
  output logic [7:0]       bus_ar_len,
  input  logic             bus_r_valid,
  input  logic             bus_r_last,
  input  logic [31:0]      bus_r_data,
  output logic             bus_r_ready,
  output logic             refill_we,
  output logic [OFF_W-1:0] refill_off,
  output logic [31:0]      refill_data,
  output logic             refill_done
);

`ifdef DCACHE_EARLY_RESTART_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {IDLE, RESP, AR, REFILL} state_t;

  state_t           state_q, state_d;
  logic [31:0]      resp_q, resp_d;
  logic [31:0]      pa_q, pa_d;
  logic             unc_q, unc_d;
  logic             cancel_q, cancel_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             early_q, early_d;
  logic             taken_q, taken_d;
  logic             beat, crit, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      resp_q   <= '0;
      pa_q     <= '0;
      unc_q    <= 1'b0;
      cancel_q <= 1'b0;
      cnt_q    <= '0;
      early_q  <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      resp_q   <= resp_d;
      pa_q     <= pa_d;
      unc_q    <= unc_d;
      cancel_q <= cancel_d;
      cnt_q    <= cnt_d;
      early_q  <= early_d;
      taken_q  <= taken_d;
    end
  end

  always_comb begin
    beat              = (state_q == REFILL) && bus_r_valid;
    crit              = beat && (unc_q ? (cnt_q == '0) : (cnt_q == pa_q[OFF_W+1:2]));
    dcache_data_valid = (state_q == RESP) || ((state_q == REFILL) && early_q);
    // rst_n gate keeps req_ready low while reset is held, not just after it
    req_ready         = rst_n && !flush_i &&
                        ((state_q == IDLE) || ((state_q == RESP) && dcache_data_ready));
    accept            = req_valid && req_ready;

    state_d  = state_q;
    resp_d   = resp_q;
    pa_d     = pa_q;
    unc_d    = unc_q;
    cancel_d = cancel_q;
    cnt_d    = cnt_q;
    early_d  = early_q;
    taken_d  = taken_q;

    case (state_q)
      IDLE, RESP: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (accept) begin
          if (req_hit && !req_uncached) begin
            resp_d  = hit_data;
            state_d = RESP;
          end else begin
            pa_d    = req_pa;
            unc_d   = req_uncached;
            state_d = AR;
          end
        end else if ((state_q == RESP) && dcache_data_ready) begin
          state_d = IDLE;
        end
      end
      AR: begin
        if (flush_i) cancel_d = 1'b1;
        if (bus_ar_ready) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        // A flush drops a pending early response; once taken it is final.
        if (flush_i) begin
          cancel_d = 1'b1;
          early_d  = 1'b0;
        end else if (early_q && dcache_data_ready) begin
          early_d = 1'b0;
          taken_d = 1'b1;
        end
        if (beat) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (crit) begin
            resp_d = bus_r_data;
            if (EARLY_EN && !unc_q && !bus_r_last && !cancel_q && !flush_i)
              early_d = 1'b1;
          end
          if (bus_r_last)
            state_d = (cancel_q || flush_i || taken_d) ? IDLE : RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != REFILL) begin
      early_d = 1'b0;
      taken_d = 1'b0;
    end
    if (state_d == IDLE) cancel_d = 1'b0;
  end

  always_comb begin
    rd_dcache_data = resp_q;
    bus_ar_valid   = (state_q == AR);
    bus_ar_addr    = '0;
    bus_ar_len     = '0;
    if (state_q == AR) begin
      bus_ar_addr = unc_q ? (pa_q & 32'hFFFF_FFFC) : (pa_q & LINE_MASK);
      bus_ar_len  = unc_q ? 8'd0 : 8'(LINE_WORDS - 1);
    end
    bus_r_ready = (state_q == REFILL);
    refill_we   = beat && !unc_q;
    refill_off  = refill_we ? cnt_q : '0;
    refill_data = refill_we ? bus_r_data : '0;
    refill_done = refill_we && bus_r_last;
  end

endmodule

// File: tb/tb_dcache_load_resp.sv
// Scoreboard bench for dcache_load_resp: directed hits, misses, uncached loads and flushes.
module tb_dcache_load_resp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_uncached, req_hit, flush_i;
  logic [31:0] req_pa, hit_data, rd_dcache_data;
  logic        dcache_data_valid, dcache_data_ready;
  logic        bus_ar_valid, bus_ar_ready;
  logic [31:0] bus_ar_addr;
  logic [7:0]  bus_ar_len;
  logic        bus_r_valid, bus_r_last, bus_r_ready;
  logic [31:0] bus_r_data;
  logic        refill_we, refill_done;
  logic [1:0]  refill_off;
  logic [31:0] refill_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  dcache_load_resp #(.LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_pa(req_pa),
    .req_uncached(req_uncached), .req_hit(req_hit), .hit_data(hit_data),
    .flush_i(flush_i), .rd_dcache_data(rd_dcache_data),
    .dcache_data_valid(dcache_data_valid), .dcache_data_ready(dcache_data_ready),
    .bus_ar_valid(bus_ar_valid), .bus_ar_ready(bus_ar_ready),
    .bus_ar_addr(bus_ar_addr), .bus_ar_len(bus_ar_len),
    .bus_r_valid(bus_r_valid), .bus_r_last(bus_r_last), .bus_r_data(bus_r_data),
    .bus_r_ready(bus_r_ready), .refill_we(refill_we), .refill_off(refill_off),
    .refill_data(refill_data), .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed response handshake is checked against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dcache_data_valid && dcache_data_ready) begin
        if (exp_q.size() == 0) chk("unexpected_resp", rd_dcache_data, 32'hxxxx_xxxx);
        else chk("resp_data", rd_dcache_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic issue(input logic [31:0] pa, input logic unc, input logic hit,
                       input logic [31:0] hd);
    req_valid = 1'b1; req_pa = pa; req_uncached = unc; req_hit = hit; hit_data = hd;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0; req_hit = 1'b0; req_uncached = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input int delay);
    int n = 0;
    while (!bus_ar_valid && n < 20) begin step(); n++; end
    @(negedge clk);
    chk("ar_valid", 32'(bus_ar_valid), 32'd1);
    chk("ar_addr", bus_ar_addr, addr);
    chk("ar_len", 32'(bus_ar_len), 32'(len));
    for (int d = 0; d < delay; d++) begin
      step();
      @(negedge clk);
      chk("ar_hold", 32'(bus_ar_valid), 32'd1);
    end
    bus_ar_ready = 1'b1;
    step();
    bus_ar_ready = 1'b0;
  endtask

  task automatic do_r(input int n, input logic [31:0] base, input logic cached);
    for (int i = 0; i < n; i++) begin
      bus_r_valid = 1'b1; bus_r_data = base + 32'(i); bus_r_last = (i == n - 1);
      @(negedge clk);
      chk("r_ready", 32'(bus_r_ready), 32'd1);
      chk("refill_we", 32'(refill_we), 32'(cached));
      if (cached) begin
        chk("refill_off", 32'(refill_off), 32'(i));
        chk("refill_data", refill_data, base + 32'(i));
      end
      chk("refill_done", 32'(refill_done), 32'(cached && (i == n - 1)));
      step();
    end
    bus_r_valid = 1'b0; bus_r_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_pa = '0; req_uncached = 1'b0; req_hit = 1'b0;
    hit_data = '0; flush_i = 1'b0; dcache_data_ready = 1'b0; bus_ar_ready = 1'b0;
    bus_r_valid = 1'b0; bus_r_last = 1'b0; bus_r_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(dcache_data_valid), 32'd0);
    chk("rst_data", rd_dcache_data, 32'd0);
    chk("rst_ar_valid", 32'(bus_ar_valid), 32'd0);
    chk("rst_r_ready", 32'(bus_r_ready), 32'd0);
    chk("rst_refill", {29'd0, refill_we, refill_done, 1'b0}, 32'd0);
    rst_n = 1'b1;
    step();

    // Hit with response stall of 3 cycles
    exp_q.push_back(32'hDEAD_BEEF);
    issue(32'h1000_0008, 1'b0, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hit_valid", 32'(dcache_data_valid), 32'd1);
      chk("hit_hold", rd_dcache_data, 32'hDEAD_BEEF);
      step();
    end
    dcache_data_ready = 1'b1;
    step();
    @(negedge clk);
    chk("hit_done_valid", 32'(dcache_data_valid), 32'd0);
    step();

    // Back-to-back hits at one per cycle
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0000_0100 + 32'(i));
      req_valid = 1'b1; req_pa = 32'h1000_0000 + 32'(i * 4); req_hit = 1'b1;
      hit_data = 32'h0000_0100 + 32'(i);
      @(negedge clk);
      chk("b2b_ready", 32'(req_ready), 32'd1);
      step();
    end
    req_valid = 1'b0; req_hit = 1'b0;
    @(negedge clk);
    chk("b2b_last_valid", 32'(dcache_data_valid), 32'd1);
    step();

    // Cacheable miss, critical word at offset 2
    exp_q.push_back(32'h0000_00A2);
    issue(32'h2000_0048, 1'b0, 1'b0, 32'h0);
    chk("miss_ar_t1", 32'(bus_ar_valid), 32'd1);
    do_ar(32'h2000_0040, 8'd3, 2);
    do_r(4, 32'h0000_00A0, 1'b1);
`ifndef DCACHE_EARLY_RESTART_EN
    @(negedge clk);
    chk("miss_valid_after_last", 32'(dcache_data_valid), 32'd1);
`endif
    step();

    // Uncached load, tag hit must be ignored
    exp_q.push_back(32'h5555_1234);
    issue(32'h1FAF_0006, 1'b1, 1'b1, 32'hFFFF_FFFF);
    do_ar(32'h1FAF_0004, 8'd0, 0);
    do_r(1, 32'h5555_1234, 1'b0);
    @(negedge clk);
    chk("unc_valid", 32'(dcache_data_valid), 32'd1);
    step();

    // Flush one cycle after ar_valid: refill completes, no response
    issue(32'h3000_0004, 1'b0, 1'b0, 32'h0);
    step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ar_hold", 32'(bus_ar_valid), 32'd1);
    step();
    flush_i = 1'b0;
    do_ar(32'h3000_0000, 8'd3, 0);
    do_r(4, 32'h0000_00C0, 1'b1);
    @(negedge clk);
    chk("flush_no_valid", 32'(dcache_data_valid), 32'd0);
    chk("flush_idle", 32'(req_ready), 32'd1);
    step();

    // Flush in RESP together with a new hit request
    dcache_data_ready = 1'b0;
    issue(32'h1000_0010, 1'b0, 1'b1, 32'h1111_1111);
    flush_i = 1'b1; req_valid = 1'b1; req_hit = 1'b1; hit_data = 32'h2222_2222;
    @(negedge clk);
    chk("flush_resp_valid", 32'(dcache_data_valid), 32'd1);
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    step();
    flush_i = 1'b0; req_valid = 1'b0; req_hit = 1'b0;
    @(negedge clk);
    chk("flush_resp_drop", 32'(dcache_data_valid), 32'd0);
    chk("flush_resp_idle", 32'(req_ready), 32'd1);
    step();
    dcache_data_ready = 1'b1;

`ifdef DCACHE_EARLY_RESTART_EN
    // Early restart: critical word at offset 1
    exp_q.push_back(32'h0000_00B1);
    issue(32'h4000_0004, 1'b0, 1'b0, 32'h0);
    do_ar(32'h4000_0000, 8'd3, 0);
    for (int i = 0; i < 4; i++) begin
      bus_r_valid = 1'b1; bus_r_data = 32'h0000_00B0 + 32'(i); bus_r_last = (i == 3);
      @(negedge clk);
      if (i == 2) chk("early_valid", 32'(dcache_data_valid), 32'd1);
      if (i >= 2) chk("early_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    bus_r_valid = 1'b0; bus_r_last = 1'b0;
    @(negedge clk);
    chk("early_idle", 32'(req_ready), 32'd1);
    chk("early_no_resp", 32'(dcache_data_valid), 32'd0);
    step();
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
